sdram_cmd: RTL
==============

SDRAM_CMD -- requirements
Module: sdram_cmd

Interface
REQ-001 Parameters (name, default, meaning): CLK_FREQ 100 clock MHz; DW 16 data width; RAW 12 SDRAM address width; tRCD 20 ns ACTIVE-to-RD/WR; tRP 20 ns PRECHARGE period; tRFC 70 ns REFRESH period; tMRD 20 ns mode-register-set period.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock, all logic on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 cmd_valid  in  1  command request, one pulse per command.
REQ-006 cmd_type  in  4  {cs_n,ras_n,cas_n,we_n} code.
REQ-007 cmd_addr  in  RAW, cmd_ba  in  2, cmd_data  in  DW, cmd_dqm  in  DW/8: command fields.
REQ-008 cmd_done  out  1, cmd_early_done  out  1, cmd_wip  out  1: completion, completion-minus-one, busy.
REQ-009 sdram_cke  out  1; sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each.
REQ-010 sdram_addr  out  RAW, sdram_ba  out  2, sdram_dqm  out  DW/8, sdram_dq_out  out  DW, sdram_dq_oe  out  1.

Function
REQ-011 Codes: LOAD_MODE 0000, REFRESH 0001, PRECHARGE 0010, ACTIVE 0011, WRITE 0100, READ 0101, NOP 0111; any other code is executed as NOP.
REQ-012 Occupancy N (cycles): ACTIVE cRCD, PRECHARGE cRP, REFRESH cRFC, LOAD_MODE cMRD, READ/WRITE/NOP 1; cX = ceil(tX*CLK_FREQ/1000), clamped to >= 1.
REQ-013 Accept: cmd_valid sampled high at cycle T while cmd_wip=0; cmd_valid while cmd_wip=1 is ignored and does not appear on the pins.
REQ-014 Pins registered: accepted command appears on cs_n/ras_n/cas_n/we_n, sdram_addr, sdram_ba at T+1 only; all other cycles drive NOP (0111) and hold the last addr/ba.
REQ-015 WRITE: sdram_dq_out=cmd_data, sdram_dqm=cmd_dqm, sdram_dq_oe=1 at T+1 only; otherwise dq_oe=0, dqm=0.
REQ-016 cmd_wip=1 for cycles T+1..T+N-1; never asserted when N=1.
REQ-017 cmd_done: registered, single-cycle pulse at T+N; same cycle cmd_wip=0, so a new command may be accepted at T+N and reaches the pins at T+N+1.
REQ-018 cmd_early_done: single-cycle pulse at T+N-1 when N>=2; never asserted when N=1.
REQ-019 No combinational path from any cmd_* input to cmd_done, cmd_early_done or cmd_wip.
REQ-020 Back-to-back READ/WRITE: one command per cycle on the pins, no NOP gaps.
REQ-021 Internal state: IDLE (no occupancy) and BUSY (down-counter loaded with N-1 at accept, decremented each cycle, done when it reaches 0); counter width = clog2 of max occupancy + 1.
REQ-022 cmd_addr is passed unmodified; A10 semantics are owned upstream.

Reset
REQ-023 While rst=1: sdram_cke=0, cs_n=1, ras_n=cas_n=we_n=1, addr=0, ba=0, dqm=0, dq_out=0, dq_oe=0, cmd_done=cmd_early_done=cmd_wip=0, counter=0, state IDLE.
REQ-024 First clock edge after rst release drives sdram_cke=1 and cs_n=0 with NOP; cke stays 1 thereafter.
REQ-025 Reset asserted mid-command aborts it immediately; no cmd_done is produced for the aborted command.

Structure
REQ-026 Command encodings and the ceil-divide function live in shared package sdram_pkg, which replaces the include-file macros for both sdram_ctrl and sdram_cmd.
REQ-027 The occupancy counter (load, decrement, done/early-done flags) is sub-module sdram_cmd_timer.

Verification (CLK_FREQ=100, defaults: cRCD=2, cRP=2, cRFC=7, cMRD=2)
REQ-028 ACTIVE at T=10 -> pins ACTIVE at 11, early_done at 11, done at 12, wip high at 11 only.
REQ-029 READ at T=10,11,12,13 -> READ on pins at 11-14 with no NOP, done at 11-14, wip never high.
REQ-030 WRITE data 0xA5A5, dqm 2'b01 -> at T+1 dq_out=0xA5A5, dqm=01, dq_oe=1; at T+2 dq_oe=0.
REQ-031 REFRESH at T=5 with cmd_valid held high for 6 more cycles -> one REFRESH at 6, NOPs at 7-12, done at 12, early_done at 11.
REQ-032 rst pulsed at T+3 during REFRESH -> all outputs at reset values in the same cycle, no cmd_done; next ACTIVE after release times normally.
REQ-033 cmd_type 1111 -> NOP on pins, done at T+1.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and timing helpers for sdram_ctrl and sdram_cmd.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n} as driven on the SDRAM pins.
  typedef enum logic [3:0] {
    CMD_LOAD_MODE = 4'b0000,
    CMD_REFRESH   = 4'b0001,
    CMD_PRECHARGE = 4'b0010,
    CMD_ACTIVE    = 4'b0011,
    CMD_WRITE     = 4'b0100,
    CMD_READ      = 4'b0101,
    CMD_NOP       = 4'b0111,
    CMD_DESELECT  = 4'b1111   // only driven while the device is held in reset
  } sdram_cmd_e;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_BUSY = 1'b1
  } tmr_state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Nanoseconds to whole clock cycles at clk_mhz, never less than one cycle.
  function automatic int ns_to_cycles(input int t_ns, input int clk_mhz);
    int c;
    c = ceil_div(t_ns * clk_mhz, 1000);
    return (c < 1) ? 1 : c;
  endfunction

  // Unknown codes execute as NOP so the pins never see an undefined command.
  function automatic sdram_cmd_e decode_cmd(input logic [3:0] code);
    case (code)
      4'b0000: return CMD_LOAD_MODE;
      4'b0001: return CMD_REFRESH;
      4'b0010: return CMD_PRECHARGE;
      4'b0011: return CMD_ACTIVE;
      4'b0100: return CMD_WRITE;
      4'b0101: return CMD_READ;
      default: return CMD_NOP;
    endcase
  endfunction

endpackage

// File: rtl/sdram_cmd_timer.sv
// Command occupancy timer: loads N-1 on accept, counts down, flags done / done-minus-one.
// Latency: done at T+N, early_done at T+N-1 (N>=2), busy for T+1..T+N-1.
// Backpressure: busy tells the owner to stop loading; load while busy is not expected.
// Ports: clk, rst (async, active-high), load + occ (occupancy N) in; busy, done, early_done out.
module sdram_cmd_timer
  import sdram_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] occ,
  output logic          busy,
  output logic          done,
  output logic          early_done
);

  tmr_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          early_q, early_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TMR_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      early_q <= early_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    early_d = 1'b0;
    case (state_q)
      TMR_IDLE: begin
        if (load) begin
          if (occ <= CW'(1)) begin
            // Single-cycle command: no busy window, done straight away.
            done_d = 1'b1;
          end else begin
            state_d = TMR_BUSY;
            cnt_d   = occ - CW'(1);
            early_d = (occ == CW'(2));
          end
        end
      end
      TMR_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(2)) early_d = 1'b1;
        if (cnt_q == CW'(1)) begin
          done_d  = 1'b1;
          state_d = TMR_IDLE;
        end
      end
      default: state_d = TMR_IDLE;
    endcase
  end

  assign busy       = (state_q == TMR_BUSY);
  assign done       = done_q;
  assign early_done = early_q;

endmodule

// File: rtl/sdram_cmd.sv
// SDRAM command issuer: registers one accepted command onto the pins and times its occupancy.
// Latency: command on pins at T+1, cmd_done at T+N (N = per-command occupancy in cycles).
// Backpressure: cmd_wip high means cmd_valid is dropped; no queueing.
// Ports: clk, rst; cmd_valid/type/addr/ba/data/dqm in; cmd_done/early_done/wip out;
//        sdram_cke, cs_n/ras_n/cas_n/we_n, addr, ba, dqm, dq_out, dq_oe out.
module sdram_cmd
  import sdram_pkg::*;
#(
  parameter int CLK_FREQ = 100,
  parameter int DW       = 16,
  parameter int RAW      = 12,
  parameter int tRCD     = 20,
  parameter int tRP      = 20,
  parameter int tRFC     = 70,
  parameter int tMRD     = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  input  logic [3:0]      cmd_type,
  input  logic [RAW-1:0]  cmd_addr,
  input  logic [1:0]      cmd_ba,
  input  logic [DW-1:0]   cmd_data,
  input  logic [DW/8-1:0] cmd_dqm,
  output logic            cmd_done,
  output logic            cmd_early_done,
  output logic            cmd_wip,
  output logic            sdram_cke,
  output logic            sdram_cs_n,
  output logic            sdram_ras_n,
  output logic            sdram_cas_n,
  output logic            sdram_we_n,
  output logic [RAW-1:0]  sdram_addr,
  output logic [1:0]      sdram_ba,
  output logic [DW/8-1:0] sdram_dqm,
  output logic [DW-1:0]   sdram_dq_out,
  output logic            sdram_dq_oe
);

  localparam int C_RCD = ns_to_cycles(tRCD, CLK_FREQ);
  localparam int C_RP  = ns_to_cycles(tRP,  CLK_FREQ);
  localparam int C_RFC = ns_to_cycles(tRFC, CLK_FREQ);
  localparam int C_MRD = ns_to_cycles(tMRD, CLK_FREQ);
  localparam int C_MAX01 = (C_RCD > C_RP)  ? C_RCD : C_RP;
  localparam int C_MAX23 = (C_RFC > C_MRD) ? C_RFC : C_MRD;
  localparam int C_MAX   = (C_MAX01 > C_MAX23) ? C_MAX01 : C_MAX23;
  localparam int CW      = $clog2(C_MAX + 1);

  sdram_cmd_e    cmd_dec;
  sdram_cmd_e    pin_cmd;
  logic [CW-1:0] occ;
  logic          busy;
  logic          accept;

  assign cmd_dec = decode_cmd(cmd_type);
  assign accept  = cmd_valid && !busy;

  always_comb begin
    occ = CW'(1);
    case (cmd_dec)
      CMD_ACTIVE:    occ = CW'(C_RCD);
      CMD_PRECHARGE: occ = CW'(C_RP);
      CMD_REFRESH:   occ = CW'(C_RFC);
      CMD_LOAD_MODE: occ = CW'(C_MRD);
      default:       occ = CW'(1);
    endcase
  end

  sdram_cmd_timer #(
    .CW(CW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .occ        (occ),
    .busy       (busy),
    .done       (cmd_done),
    .early_done (cmd_early_done)
  );

  assign cmd_wip = busy;

  // Pins default to NOP every cycle; addr/ba hold so the bus only toggles on real commands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdram_cke    <= 1'b0;
      pin_cmd      <= CMD_DESELECT;
      sdram_addr   <= '0;
      sdram_ba     <= '0;
      sdram_dqm    <= '0;
      sdram_dq_out <= '0;
      sdram_dq_oe  <= 1'b0;
    end else begin
      sdram_cke   <= 1'b1;
      pin_cmd     <= CMD_NOP;
      sdram_dqm   <= '0;
      sdram_dq_oe <= 1'b0;
      if (accept) begin
        pin_cmd    <= cmd_dec;
        sdram_addr <= cmd_addr;
        sdram_ba   <= cmd_ba;
        if (cmd_dec == CMD_WRITE) begin
          sdram_dq_out <= cmd_data;
          sdram_dqm    <= cmd_dqm;
          sdram_dq_oe  <= 1'b1;
        end
      end
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pin_cmd;

endmodule
